ama_riscv_retire_trace: RTL and testbench
=========================================

Name: ama_riscv_retire_trace

Overview:
- Hardware retirement monitor downstream of ama_riscv_core_top's writeback stage.
- Each cycle it samples the writeback PC/instruction and the nop/clear flag, and keeps cycle and retired-instruction counters.
- Retired entries are pushed into a FIFO drained over a valid/ready port by the bench, cosim bridge or debug UART.
- Capture freezes once tohost is written, after retiring the tohost CSR instruction plus one more slot.

Parameters:
- DEPTH, 16, trace FIFO entries; power of two, min 2.
- CNT_W, 64, width of the cycle and instruction counters.
- POST_TOHOST_SLOTS, 1, writeback slots still sampled after tohost[0] rises.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- pc_wbk  in  32  writeback PC.
- inst_wbk  in  32  writeback instruction.
- inst_wb_nop_or_clear  in  1  1 = no retirement this cycle.
- tohost  in  1  csr_tohost[0] from core.
- mmio_reset_cnt  in  1  synchronous clear of counters and the overflow count.
- tr_valid  out  1  FIFO head valid.
- tr_ready  in  1  consumer accepts head.
- tr_pc  out  32  head PC.
- tr_inst  out  32  head instruction.
- tr_seq  out  CNT_W  instruction count at that retirement (1-based).
- cycle_cnt  out  CNT_W  cycles since reset or clear while RUN.
- instr_cnt  out  CNT_W  retired instructions.
- ovf_cnt  out  16  dropped entries, saturating.
- frozen  out  1  capture stopped.

Behaviour:
- Reset (async, rst_n=0): state=RUN. All counters 0, FIFO empty, tr_valid=0, frozen=0. tr_pc/tr_inst/tr_seq are 0 while empty.
- Retire event: state≠FROZEN and inst_wb_nop_or_clear=0.
- Counters:
  - cycle_cnt +1 every cycle not FROZEN.
  - instr_cnt +1 on each retire event.
  - Counters wrap modulo 2^CNT_W.
- mmio_reset_cnt=1: cycle_cnt, instr_cnt and ovf_cnt become 0 next cycle. It wins over increments in the same cycle. The FIFO is untouched.
- Push on a retire event: entry {pc_wbk, inst_wbk, instr_cnt+1}, visible on tr_* the next cycle if the FIFO was empty (1-cycle latency).
- Pop when tr_valid & tr_ready.
- Push with the FIFO full and no pop in the same cycle: entry dropped, ovf_cnt +1 (saturates at 16'hFFFF), instr_cnt still increments. Full with a same-cycle pop: push accepted.
- Pop+push when the FIFO is empty is impossible (tr_valid=0). Push when the FIFO has exactly 1 entry and a pop occurs: occupancy stays 1.
- tr_* is stable while tr_valid & !tr_ready.
- FSM:
  - RUN: on tohost rising edge (tohost=1 and the registered previous value =0) go to DRAIN with slot_cnt=POST_TOHOST_SLOTS. The retire in that cycle is still captured.
  - DRAIN: counting continues. slot_cnt decrements each cycle. When slot_cnt==1 and decrementing, go to FROZEN next cycle. If POST_TOHOST_SLOTS=0, RUN goes directly to FROZEN.
  - FROZEN: frozen=1, no counting, no pushes, pops still allowed. Left only by reset.
- tohost held high or toggling after DRAIN is entered: ignored.
- mmio_reset_cnt during FROZEN clears the counters, which stay at 0.

Optional Feature:
- RETIRE_TRACE_BP_EN.
- Defined: adds inputs br_taken_wbk (1) and br_mispred_wbk (1), and output tr_br (2, {taken, mispred}) carried in the FIFO entry. Adds outputs br_cnt and mispred_cnt (CNT_W), which count on retire events, are cleared by mmio_reset_cnt, and reset to 0.
- Undefined: none of these ports or registers exist.

Decomposition:
- ama_riscv_trace_pkg: trace_entry_t struct (pc, inst, seq, optional br); trace_state_e {TR_RUN, TR_DRAIN, TR_FROZEN}; OVF_W=16 localparam.
- Sub-module ama_riscv_trace_fifo: generic synchronous FIFO of trace_entry_t. Interface: push/full, pop/valid. Async active-low reset. Top holds the FSM, counters and drop logic.

Test Plan:
- Reset, 10 cycles with nop_or_clear=1, then 3 retires at pc 0x100/0x104/0x108 with tr_ready=1 -> tr_seq 1,2,3 one cycle after each push; instr_cnt=3; cycle_cnt=13.
- DEPTH=16, tr_ready=0, 20 back-to-back retires -> FIFO holds seq 1..16, ovf_cnt=4, instr_cnt=20. Then tr_ready=1 -> 16 pops, tr_valid drops, seq 17..20 never appear.
- tohost rises during a retire of pc 0x200, next cycle retires pc 0x204, following cycle retires pc 0x208 -> 0x200 and 0x204 captured, 0x208 not; frozen=1; cycle_cnt stops.
- mmio_reset_cnt=1 in the same cycle as a retire with instr_cnt=5 -> instr_cnt=0 next cycle, entry pushed with seq 6; the next retire gives seq 1.
- rst_n asserted mid-stream with 5 entries queued -> tr_valid=0 immediately (async), counters 0, state RUN after release.
- RETIRE_TRACE_BP_EN: 4 branches, 3 taken, 1 mispredicted -> br_cnt=3, mispred_cnt=1, tr_br of the mispredicted entry = 2'b11.

Source files
------------

// File: rtl/ama_riscv_trace_pkg.sv
// rtl/ama_riscv_trace_pkg.sv - shared types for the retirement trace monitor (RETIRE_TRACE_BP_EN adds branch bits)
package ama_riscv_trace_pkg;

  localparam int OVF_W = 16;
  // Entries carry the widest supported sequence number; narrower CNT_W builds zero-extend.
  localparam int SEQ_W = 64;

  typedef enum logic [1:0] {
    TR_RUN,
    TR_DRAIN,
    TR_FROZEN
  } trace_state_e;

  typedef struct packed {
    logic [31:0]      pc;
    logic [31:0]      inst;
    logic [SEQ_W-1:0] seq;
`ifdef RETIRE_TRACE_BP_EN
    logic [1:0]       br;
`endif
  } trace_entry_t;

endpackage

// File: rtl/ama_riscv_retire_trace_if.sv
// rtl/ama_riscv_retire_trace_if.sv - trace drain port (RETIRE_TRACE_BP_EN adds tr_br)
interface ama_riscv_retire_trace_if #(
  parameter int CNT_W = 64
) ();

  logic             tr_valid;
  logic             tr_ready;
  logic [31:0]      tr_pc;
  logic [31:0]      tr_inst;
  logic [CNT_W-1:0] tr_seq;
`ifdef RETIRE_TRACE_BP_EN
  logic [1:0]       tr_br;
`endif

  modport master (
    output tr_valid, tr_pc, tr_inst, tr_seq,
`ifdef RETIRE_TRACE_BP_EN
    output tr_br,
`endif
    input  tr_ready
  );

  modport slave (
    input  tr_valid, tr_pc, tr_inst, tr_seq,
`ifdef RETIRE_TRACE_BP_EN
    input  tr_br,
`endif
    output tr_ready
  );

endinterface

// File: rtl/ama_riscv_trace_fifo.sv
// rtl/ama_riscv_trace_fifo.sv - synchronous FIFO of trace entries, head forced to zero when empty
module ama_riscv_trace_fifo
  import ama_riscv_trace_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  trace_entry_t din,
  output logic         full,
  input  logic         pop,
  output logic         valid,
  output trace_entry_t dout
);

  localparam int AW = $clog2(DEPTH);

  trace_entry_t  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign valid   = (count != '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop & valid;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);
  assign dout    = valid ? mem[rd_ptr] : '0;

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; the head is masked until written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/ama_riscv_retire_trace.sv
// rtl/ama_riscv_retire_trace.sv - retirement monitor with counters, freeze FSM and trace FIFO (RETIRE_TRACE_BP_EN adds branch stats)
module ama_riscv_retire_trace
  import ama_riscv_trace_pkg::*;
#(
  parameter int DEPTH             = 16,
  parameter int CNT_W             = 64,
  parameter int POST_TOHOST_SLOTS = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [31:0]        pc_wbk,
  input  logic [31:0]        inst_wbk,
  input  logic               inst_wb_nop_or_clear,
  input  logic               tohost,
  input  logic               mmio_reset_cnt,
`ifdef RETIRE_TRACE_BP_EN
  input  logic               br_taken_wbk,
  input  logic               br_mispred_wbk,
  output logic [CNT_W-1:0]   br_cnt,
  output logic [CNT_W-1:0]   mispred_cnt,
`endif
  ama_riscv_retire_trace_if.master tr,
  output logic [CNT_W-1:0]   cycle_cnt,
  output logic [CNT_W-1:0]   instr_cnt,
  output logic [OVF_W-1:0]   ovf_cnt,
  output logic               frozen
);

  localparam int SLOT_W = (POST_TOHOST_SLOTS > 1) ? $clog2(POST_TOHOST_SLOTS + 1) : 1;

  trace_state_e      state_q, state_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic              tohost_q;
  logic              running;
  logic              retire;
  logic              fifo_full;
  logic              fifo_valid;
  logic              pop;
  logic              drop;
  logic [CNT_W-1:0]  seq_next;
  trace_entry_t      entry;
  trace_entry_t      head;

  assign running  = (state_q != TR_FROZEN);
  assign retire   = running & ~inst_wb_nop_or_clear;
  assign pop      = fifo_valid & tr.tr_ready;
  assign drop     = retire & fifo_full & ~pop;
  assign seq_next = instr_cnt + 1'b1;
  assign frozen   = (state_q == TR_FROZEN);

  // Pack the retiring instruction into a FIFO entry.
  always_comb begin
    entry      = '0;
    entry.pc   = pc_wbk;
    entry.inst = inst_wbk;
    entry.seq  = SEQ_W'(seq_next);
`ifdef RETIRE_TRACE_BP_EN
    entry.br   = {br_taken_wbk, br_mispred_wbk};
`endif
  end

  ama_riscv_trace_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (retire),
    .din   (entry),
    .full  (fifo_full),
    .pop   (pop),
    .valid (fifo_valid),
    .dout  (head)
  );

  assign tr.tr_valid = fifo_valid;
  assign tr.tr_pc    = head.pc;
  assign tr.tr_inst  = head.inst;
  assign tr.tr_seq   = head.seq[CNT_W-1:0];
`ifdef RETIRE_TRACE_BP_EN
  assign tr.tr_br    = head.br;
`endif

  // FSM state, drain slot counter and tohost edge history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= TR_RUN;
      slot_q   <= '0;
      tohost_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      slot_q   <= slot_d;
      tohost_q <= tohost;
    end
  end

  // Next state: a tohost rising edge in RUN starts the post-tohost drain window.
  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    case (state_q)
      TR_RUN: begin
        if (tohost && !tohost_q) begin
          if (POST_TOHOST_SLOTS == 0) begin
            state_d = TR_FROZEN;
          end else begin
            state_d = TR_DRAIN;
            slot_d  = SLOT_W'(POST_TOHOST_SLOTS);
          end
        end
      end
      TR_DRAIN: begin
        slot_d = slot_q - 1'b1;
        if (slot_q == SLOT_W'(1)) state_d = TR_FROZEN;
      end
      default: begin
        state_d = TR_FROZEN;
      end
    endcase
  end

  // Cycle, retire and overflow counters; the MMIO clear beats any increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt <= '0;
      instr_cnt <= '0;
      ovf_cnt   <= '0;
    end else if (mmio_reset_cnt) begin
      cycle_cnt <= '0;
      instr_cnt <= '0;
      ovf_cnt   <= '0;
    end else begin
      if (running) cycle_cnt <= cycle_cnt + 1'b1;
      if (retire)  instr_cnt <= seq_next;
      if (drop && (ovf_cnt != {OVF_W{1'b1}})) ovf_cnt <= ovf_cnt + 1'b1;
    end
  end

`ifdef RETIRE_TRACE_BP_EN
  // Branch statistics gathered on retire events only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_cnt      <= '0;
      mispred_cnt <= '0;
    end else if (mmio_reset_cnt) begin
      br_cnt      <= '0;
      mispred_cnt <= '0;
    end else begin
      if (retire && br_taken_wbk)   br_cnt      <= br_cnt + 1'b1;
      if (retire && br_mispred_wbk) mispred_cnt <= mispred_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_ama_riscv_retire_trace.sv
// tb/tb_ama_riscv_retire_trace.sv - scoreboard bench for the retirement trace monitor (RETIRE_TRACE_BP_EN checks branch stats)
module tb_ama_riscv_retire_trace;
  import ama_riscv_trace_pkg::*;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [63:0] seq;
    logic [1:0]  br;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] pc_wbk = '0;
  logic [31:0] inst_wbk = '0;
  logic        nop = 1'b1;
  logic        tohost = 1'b0;
  logic        mmio = 1'b0;
  logic [63:0] cycle_cnt;
  logic [63:0] instr_cnt;
  logic [15:0] ovf_cnt;
  logic        frozen;
`ifdef RETIRE_TRACE_BP_EN
  logic        br_taken = 1'b0;
  logic        br_mispred = 1'b0;
  logic [63:0] br_cnt;
  logic [63:0] mispred_cnt;
`endif

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  ama_riscv_retire_trace_if #(.CNT_W(64)) tif ();

  ama_riscv_retire_trace #(.DEPTH(16), .CNT_W(64), .POST_TOHOST_SLOTS(1)) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .pc_wbk               (pc_wbk),
    .inst_wbk             (inst_wbk),
    .inst_wb_nop_or_clear (nop),
    .tohost               (tohost),
    .mmio_reset_cnt       (mmio),
`ifdef RETIRE_TRACE_BP_EN
    .br_taken_wbk         (br_taken),
    .br_mispred_wbk       (br_mispred),
    .br_cnt               (br_cnt),
    .mispred_cnt          (mispred_cnt),
`endif
    .tr                   (tif),
    .cycle_cnt            (cycle_cnt),
    .instr_cnt            (instr_cnt),
    .ovf_cnt              (ovf_cnt),
    .frozen               (frozen)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One retire slot; the entry is queued as expected only when it must be captured.
  task automatic retire(input logic [31:0] pc, input logic cap, input logic [63:0] seq, input logic [1:0] br);
    exp_t e;
    pc_wbk   = pc;
    inst_wbk = {pc[15:0], 16'h0013};
    nop      = 1'b0;
`ifdef RETIRE_TRACE_BP_EN
    br_taken   = br[1];
    br_mispred = br[0];
`endif
    if (cap) begin
      e.pc = pc; e.inst = {pc[15:0], 16'h0013}; e.seq = seq; e.br = br;
      exp_q.push_back(e);
    end
    tick();
    nop = 1'b1;
  endtask

  task automatic drain(input string name);
    tif.tr_ready = 1'b1;
    for (int k = 0; k < 60 && exp_q.size() != 0; k++) tick();
    tick();
    check({name, "_left"}, 64'(exp_q.size()), 64'd0);
    check({name, "_valid"}, {63'd0, tif.tr_valid}, 64'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; nop = 1'b1; tohost = 1'b0; mmio = 1'b0; tif.tr_ready = 1'b0;
    exp_q.delete();
    repeat (3) tick();
    rst_n = 1'b1;
  endtask

  // Monitor: every accepted head is compared against the oldest expected entry.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && tif.tr_valid && tif.tr_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_entry: got pc=0x%0h seq=%0d, want none", tif.tr_pc, tif.tr_seq);
      end else begin
        e = exp_q.pop_front();
        check("tr_pc", {32'd0, tif.tr_pc}, {32'd0, e.pc});
        check("tr_inst", {32'd0, tif.tr_inst}, {32'd0, e.inst});
        check("tr_seq", tif.tr_seq, e.seq);
`ifdef RETIRE_TRACE_BP_EN
        check("tr_br", {62'd0, tif.tr_br}, {62'd0, e.br});
`endif
      end
    end
  end

  initial begin
    tif.tr_ready = 1'b0;

    // Reset state and basic capture
    rst_n = 1'b0;
    repeat (2) tick();
    check("rst_valid", {63'd0, tif.tr_valid}, 64'd0);
    check("rst_pc", {32'd0, tif.tr_pc}, 64'd0);
    check("rst_seq", tif.tr_seq, 64'd0);
    check("rst_cycle", cycle_cnt, 64'd0);
    check("rst_instr", instr_cnt, 64'd0);
    check("rst_ovf", {48'd0, ovf_cnt}, 64'd0);
    check("rst_frozen", {63'd0, frozen}, 64'd0);
    rst_n = 1'b1;
    tif.tr_ready = 1'b1;
    repeat (10) tick();
    retire(32'h100, 1'b1, 64'd1, 2'b00);
    check("lat_valid", {63'd0, tif.tr_valid}, 64'd1);
    check("lat_seq", tif.tr_seq, 64'd1);
    retire(32'h104, 1'b1, 64'd2, 2'b00);
    retire(32'h108, 1'b1, 64'd3, 2'b00);
    check("t1_instr", instr_cnt, 64'd3);
    check("t1_cycle", cycle_cnt, 64'd13);
    drain("t1_drain");

    // Overflow with a stalled consumer
    tif.tr_ready = 1'b0;
    mmio = 1'b1;
    tick();
    mmio = 1'b0;
    check("clr_cycle", cycle_cnt, 64'd0);
    check("clr_instr", instr_cnt, 64'd0);
    for (int i = 0; i < 20; i++)
      retire(32'h1000 + 32'(4 * i), (i < 16), 64'(i + 1), 2'b00);
    check("ovf_cnt", {48'd0, ovf_cnt}, 64'd4);
    check("ovf_instr", instr_cnt, 64'd20);
    tick();
    check("stall_seq", tif.tr_seq, 64'd1);
    check("stall_pc", {32'd0, tif.tr_pc}, 64'h1000);
    tif.tr_ready = 1'b1;
    retire(32'h2000, 1'b1, 64'd21, 2'b00);
    check("full_pop_ovf", {48'd0, ovf_cnt}, 64'd4);
    drain("t2_drain");

    // MMIO clear coincident with a retire
    mmio = 1'b1;
    tick();
    mmio = 1'b0;
    check("clr_ovf", {48'd0, ovf_cnt}, 64'd0);
    for (int i = 0; i < 5; i++)
      retire(32'h400 + 32'(4 * i), 1'b1, 64'(i + 1), 2'b00);
    check("pre_clr_instr", instr_cnt, 64'd5);
    mmio = 1'b1;
    retire(32'h414, 1'b1, 64'd6, 2'b00);
    mmio = 1'b0;
    check("clr_win_instr", instr_cnt, 64'd0);
    retire(32'h418, 1'b1, 64'd1, 2'b00);
    check("post_clr_instr", instr_cnt, 64'd1);
    drain("t3_drain");

    // Asynchronous reset with entries queued
    tif.tr_ready = 1'b0;
    for (int i = 0; i < 5; i++)
      retire(32'h600 + 32'(4 * i), 1'b0, 64'd0, 2'b00);
    check("q5_valid", {63'd0, tif.tr_valid}, 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_valid", {63'd0, tif.tr_valid}, 64'd0);
    check("async_instr", instr_cnt, 64'd0);
    check("async_cycle", cycle_cnt, 64'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tif.tr_ready = 1'b1;
    retire(32'h300, 1'b1, 64'd1, 2'b00);
    tick();
    check("rerun_frozen", {63'd0, frozen}, 64'd0);
    check("rerun_cycle", cycle_cnt, 64'd2);
    check("rerun_instr", instr_cnt, 64'd1);

    // tohost freeze: the tohost retire and one more slot are captured
    tohost = 1'b1;
    retire(32'h200, 1'b1, 64'd2, 2'b00);
    check("drain_frozen", {63'd0, frozen}, 64'd0);
    retire(32'h204, 1'b1, 64'd3, 2'b00);
    check("frozen", {63'd0, frozen}, 64'd1);
    retire(32'h208, 1'b0, 64'd0, 2'b00);
    tohost = 1'b0;
    tick();
    tohost = 1'b1;
    repeat (2) tick();
    check("frz_cycle", cycle_cnt, 64'd4);
    check("frz_instr", instr_cnt, 64'd3);
    check("frz_still", {63'd0, frozen}, 64'd1);
    drain("t5_drain");
    tohost = 1'b0;
    mmio = 1'b1;
    tick();
    mmio = 1'b0;
    repeat (2) tick();
    check("frz_clr_cycle", cycle_cnt, 64'd0);
    check("frz_clr_instr", instr_cnt, 64'd0);

`ifdef RETIRE_TRACE_BP_EN
    // Branch statistics
    do_reset();
    tif.tr_ready = 1'b1;
    retire(32'h500, 1'b1, 64'd1, 2'b10);
    retire(32'h504, 1'b1, 64'd2, 2'b11);
    retire(32'h508, 1'b1, 64'd3, 2'b10);
    retire(32'h50C, 1'b1, 64'd4, 2'b00);
    check("br_cnt", br_cnt, 64'd3);
    check("mispred_cnt", mispred_cnt, 64'd1);
    drain("bp_drain");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
